// File: rtl/alu_issue_stage.sv
// Issue stage wrapped around the external combinational 4-bit ALU.
// Buffers commands in a FIFO, issues them one at a time and holds each result until the consumer takes it.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [3:0]       in_sel,
    input  logic             in_use_acc,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [4:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4:0]       res_data,
    output logic [3:0]       res_sel,
    output logic             res_zero,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       use_acc;
        logic [3:0] sel;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       acc;

    cmd_t head;
    logic full;
    logic empty;
    logic push;
    logic issue;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // in_ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign issue    = !empty && (!res_valid || res_ready);

    // NOTE: every output of a combinational block gets a default first; otherwise an unassigned path infers a latch.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (!empty) begin
            alu_a   = head.use_acc ? acc : head.a;
            alu_b   = head.b;
            alu_sel = head.sel;
        end
    end

    // NOTE: the command storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{use_acc: in_use_acc, sel: in_sel, b: in_b, a: in_a};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Result slot: refilled on issue, otherwise cleared only when consumed; payload holds after consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_zero  <= 1'b1;
            acc       <= '0;
        end else if (issue) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_sel   <= head.sel;
            res_zero  <= (alu_out == 5'd0);
            acc       <= alu_out[3:0];
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (issue && (head.sel >= 4'd13) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random traffic against a queue-based model.
module tb_alu_issue_stage;

    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [3:0]       in_sel;
    logic             in_use_acc;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_sel;
    logic [4:0]       alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_data;
    logic [3:0]       res_sel;
    logic             res_zero;
    logic [ERR_W-1:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Bench-side ALU; opcodes 13..15 are illegal and produce 0.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        case (sel)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a} + 5'd1;
            4'd3:    return {1'b0, a} - 5'd1;
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {1'b0, ~a};
            4'd7:    return {1'b0, a ^ b};
            4'd8:    return {a, 1'b0};
            4'd9:    return {2'b00, a[3:1]};
            4'd10:   return {1'b0, b};
            4'd11:   return {1'b0, a};
            4'd12:   return {4'd0, a == b};
            default: return 5'd0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

    alu_issue_stage #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .in_use_acc(in_use_acc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .res_zero  (res_zero),
        .err_cnt   (err_cnt)
    );

    // Reference model: a queue of pending commands and a single result slot.
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic       ua;
    } cmd_t;

    cmd_t       q[$];
    logic       m_rv;
    logic [4:0] m_rdata;
    logic [3:0] m_rsel;
    logic [3:0] m_acc;
    int         m_err;

    task automatic model_reset();
        q.delete();
        m_rv    = 1'b0;
        m_rdata = 5'd0;
        m_rsel  = 4'd0;
        m_acc   = 4'd0;
        m_err   = 0;
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, return at the following falling edge.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] sel, input logic ua, input logic rr);
        cmd_t c;
        cmd_t h;
        bit   do_push;
        bit   do_issue;
        logic [3:0] opa;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_sel     = sel;
        in_use_acc = ua;
        res_ready  = rr;
        @(posedge clk);
        do_push  = v && (q.size() < DEPTH);
        do_issue = (q.size() > 0) && (!m_rv || rr);
        if (do_issue) begin
            h       = q.pop_front();
            opa     = h.ua ? m_acc : h.a;
            m_rdata = alu_fn(opa, h.b, h.sel);
            m_rsel  = h.sel;
            m_rv    = 1'b1;
            m_acc   = m_rdata[3:0];
            if (h.sel >= 4'd13 && m_err < 255) m_err++;
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
        if (do_push) begin
            c.a = a; c.b = b; c.sel = sel; c.ua = ua;
            q.push_back(c);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, rr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; in_use_acc = 1'b0; res_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({in_ready, res_valid, res_data, res_sel, res_zero} !== {1'b1, 1'b0, 5'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b rv=%0b data=%0d sel=%0d zero=%0b, expected 1 0 0 0 1",
                     in_ready, res_valid, res_data, res_sel, res_zero);
        end
        n_assert++;
        if ({err_cnt, alu_a, alu_b, alu_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_err_alu: got err=%0d a=%0d b=%0d sel=%0d, expected all 0", err_cnt, alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 4'd3, 4'd4, 4'd0, 1'b0, 1'b1);
        n_assert++;
        if ({alu_a, alu_b, alu_sel, res_valid} !== {4'd3, 4'd4, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_issue: got a=%0d b=%0d sel=%0d rv=%0b, expected 3 4 0 0", alu_a, alu_b, alu_sel, res_valid);
        end
        idle(1'b1);
        n_assert++;
        if ({res_valid, res_data, res_sel, res_zero} !== {1'b1, 5'd7, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got rv=%0b data=%0d sel=%0d zero=%0b, expected 1 7 0 0",
                     res_valid, res_data, res_sel, res_zero);
        end
        idle(1'b1);
        n_assert++;
        if (res_valid !== 1'b0 || res_data !== 5'd7) begin
            n_fail++;
            $display("FAIL basic_consume: got rv=%0b data=%0d, expected rv=0 data held 7", res_valid, res_data);
        end
    endtask

    task automatic test_carry_zero();
        step(1'b1, 4'd9, 4'd8, 4'd0, 1'b0, 1'b1);
        idle(1'b1);
        n_assert++;
        if (res_valid !== 1'b1 || res_data !== 5'd17 || res_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL carry: got rv=%0b data=%0d zero=%0b, expected 1 17 0", res_valid, res_data, res_zero);
        end
        step(1'b1, 4'd5, 4'd5, 4'd7, 1'b0, 1'b1);
        idle(1'b1);
        n_assert++;
        if (res_valid !== 1'b1 || res_data !== 5'd0 || res_zero !== 1'b1 || res_sel !== 4'd7) begin
            n_fail++;
            $display("FAIL zero: got rv=%0b data=%0d zero=%0b sel=%0d, expected 1 0 1 7", res_valid, res_data, res_zero, res_sel);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        // Commands i=0..4 compute (i+1)+1 with opcode 2, so results are 2..6.
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 1), 4'd1, 4'd2, 1'b0, 1'b0);
        n_assert++;
        if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 5'd2) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%0b rv=%0b data=%0d, expected 0 1 2", in_ready, res_valid, res_data);
        end
        step(1'b1, 4'd15, 4'd15, 4'd0, 1'b0, 1'b0);
        n_assert++;
        if (in_ready !== 1'b0 || res_data !== 5'd2 || q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL bp_sixth: got rdy=%0b data=%0d, expected rdy=0 data held 2", in_ready, res_data);
        end
        for (int i = 1; i < 5; i++) begin
            idle(1'b1);
            n_assert++;
            if (res_valid !== 1'b1 || res_data !== 5'(i + 2) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got rv=%0b data=%0d rdy=%0b, expected 1 %0d 1", i, res_valid, res_data, in_ready, i + 2);
            end
        end
        idle(1'b1);
        n_assert++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got rv=%0b, expected 0", res_valid);
        end
    endtask

    task automatic test_chaining();
        logic [4:0] exp_r [3];
        exp_r[0] = 5'd5; exp_r[1] = 5'd6; exp_r[2] = 5'd10;
        step(1'b1, 4'd2, 4'd3, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd15, 4'd1, 4'd2, 1'b1, 1'b1);
        n_assert++;
        if (res_data !== exp_r[0]) begin
            n_fail++;
            $display("FAIL chain0: got %0d, expected %0d", res_data, exp_r[0]);
        end
        step(1'b1, 4'd15, 4'd4, 4'd0, 1'b1, 1'b1);
        n_assert++;
        if (res_data !== exp_r[1]) begin
            n_fail++;
            $display("FAIL chain1: got %0d, expected %0d", res_data, exp_r[1]);
        end
        idle(1'b1);
        n_assert++;
        if (res_data !== exp_r[2] || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL chain2: got %0d rv=%0b, expected %0d rv=1", res_data, res_valid, exp_r[2]);
        end
        idle(1'b1);
    endtask

    task automatic test_illegal();
        for (int s = 13; s <= 15; s++) begin
            step(1'b1, 4'd7, 4'd3, 4'(s), 1'b0, 1'b1);
        end
        idle(1'b1);
        n_assert++;
        if (res_data !== 5'd0 || res_sel !== 4'd15 || res_zero !== 1'b1 || err_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL illegal: got data=%0d sel=%0d zero=%0b err=%0d, expected 0 15 1 3", res_data, res_sel, res_zero, err_cnt);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] es;
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom_range(0, 99) < 55));
            ea = 4'd0; eb = 4'd0; es = 4'd0;
            if (q.size() > 0) begin
                ea = q[0].ua ? m_acc : q[0].a;
                eb = q[0].b;
                es = q[0].sel;
            end
            n_assert++;
            if (res_valid !== m_rv || res_data !== m_rdata || res_sel !== m_rsel || res_zero !== (m_rdata == 5'd0)) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: got rv=%0b data=%0d sel=%0d zero=%0b, expected %0b %0d %0d %0b",
                         i, res_valid, res_data, res_sel, res_zero, m_rv, m_rdata, m_rsel, m_rdata == 5'd0);
            end
            n_assert++;
            if (in_ready !== (q.size() < DEPTH) || err_cnt !== 8'(m_err) ||
                alu_a !== ea || alu_b !== eb || alu_sel !== es) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got rdy=%0b err=%0d a=%0d b=%0d sel=%0d, expected %0b %0d %0d %0d %0d",
                         i, in_ready, err_cnt, alu_a, alu_b, alu_sel, q.size() < DEPTH, m_err, ea, eb, es);
            end
        end
        while (q.size() > 0 || m_rv) idle(1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) step(1'b1, 4'($urandom), 4'($urandom), 4'(13 + $urandom_range(0, 2)), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_assert++;
        if (err_cnt !== 8'd255 || m_err != 255) begin
            n_fail++;
            $display("FAIL saturation: got err=%0d, expected 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 4'd1, 4'd0, 1'b0, 1'b0);
        n_assert++;
        if (res_valid !== 1'b1 || q.size() != 3) begin
            n_fail++;
            $display("FAIL mid_setup: got rv=%0b, expected 1 with 3 queued", res_valid);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got rv=%0b rdy=%0b err=%0d, expected 0 1 0", res_valid, in_ready, err_cnt);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            n_assert++;
            if (res_valid !== 1'b0 || alu_sel !== 4'd0 || alu_a !== 4'd0) begin
                n_fail++;
                $display("FAIL mid_stale%0d: got rv=%0b a=%0d sel=%0d, expected 0 0 0", i, res_valid, alu_a, alu_sel);
            end
        end
        step(1'b1, 4'd9, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);
        n_assert++;
        if (res_valid !== 1'b1 || res_data !== 5'd0 || res_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_acc: got rv=%0b data=%0d zero=%0b, expected 1 0 1", res_valid, res_data, res_zero);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_zero();
        test_backpressure();
        test_chaining();
        test_illegal();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
